// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial line signals between a processing unit and uart_tx
interface uart_tx_if;
   logic [7:0] i_data;
   logic       i_data_valid;
   logic       i_en_par;
   logic       i_par_type;
   logic       o_tx;
   logic       o_busy;
   logic       o_done;
   modport master (output i_data, i_data_valid, i_en_par, i_par_type, input o_tx, o_busy, o_done);
   modport slave  (input i_data, i_data_valid, i_en_par, i_par_type, output o_tx, o_busy, o_done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter (start, 8 data bits LSB first, optional parity, stop); the parity bit exists only when UART_TX_PARITY_EN is defined
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8
) (
   input logic      i_clk,
   input logic      i_rst,
   uart_tx_if.slave bus
);
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t                r_state, w_state;
   logic [CW-1:0]         r_cnt;
   logic [2:0]            r_bit;
   logic [DATA_WIDTH-1:0] r_shift, w_shift;
   logic                  r_tx, r_done, w_tx, w_done;
   logic                  w_bit_end, w_last, w_accept;
`ifdef UART_TX_PARITY_EN
   logic                  r_par, r_en_par;
`else
   logic                  w_unused;
   assign w_unused = bus.i_en_par ^ bus.i_par_type;
`endif
   assign w_bit_end = r_cnt == CW'(PRESCALE - 1);
   assign w_last    = r_bit == 3'(DATA_WIDTH - 1);
   assign w_accept  = r_state == IDLE && bus.i_data_valid;
   assign w_shift   = w_accept ? bus.i_data : (r_state == DATA && w_bit_end) ? r_shift >> 1 : r_shift;
   assign bus.o_tx   = r_tx;
   assign bus.o_busy = r_state != IDLE;
   assign bus.o_done = r_done;

   // next state, frame-complete pulse and the line level for the coming cycle
   always_comb begin
      w_state = r_state;
      w_done  = 1'b0;
      w_tx    = 1'b1;
      case (r_state)
         IDLE:    w_state = w_accept ? START : IDLE;
         START:   w_state = w_bit_end ? DATA : START;
`ifdef UART_TX_PARITY_EN
         DATA:    w_state = (w_bit_end && w_last) ? (r_en_par ? PARITY : STOP) : DATA;
         PARITY:  w_state = w_bit_end ? STOP : PARITY;
`else
         DATA:    w_state = (w_bit_end && w_last) ? STOP : DATA;
`endif
         STOP: begin
            w_state = w_bit_end ? IDLE : STOP;
            w_done  = w_bit_end;
         end
         default: w_state = IDLE;
      endcase
      case (w_state)
         START:   w_tx = 1'b0;
         DATA:    w_tx = w_shift[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_tx = r_par;
`endif
         default: w_tx = 1'b1;
      endcase
   end

   // state, bit-period prescaler, bit counter, shift register and registered line
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= (r_state == IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
         r_bit   <= (r_state == DATA) ? r_bit + 3'(w_bit_end) : '0;
         r_shift <= w_shift;
         r_tx    <= w_tx;
         r_done  <= w_done;
      end
   end

`ifdef UART_TX_PARITY_EN
   // parity enable and parity bit captured with the byte at accept
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_par    <= 1'b0;
         r_en_par <= 1'b0;
      end else if (w_accept) begin
         r_par    <= ^bus.i_data ^ bus.i_par_type;
         r_en_par <= bus.i_en_par;
      end
   end
`endif
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx; a frame-level model is compared every cycle, plus directed literal frames
module tb_uart_tx;
   localparam int P = 8;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   bit   chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   uart_tx_if bus();
   uart_tx_if bus1();
   uart_tx #(.PRESCALE(P)) dut  (.i_clk(clk), .i_rst(rst_n), .bus(bus));
   uart_tx #(.PRESCALE(1)) dut1 (.i_clk(clk), .i_rst(rst_n), .bus(bus1));
   assign bus1.i_data       = bus.i_data;
   assign bus1.i_data_valid = bus.i_data_valid;
   assign bus1.i_en_par     = bus.i_en_par;
   assign bus1.i_par_type   = bus.i_par_type;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // frame model: bit list built from the byte, position from cycles since accept
   int          m_cyc, m_len;
   logic [10:0] m_frame;
   logic        m_done;

   function automatic logic [10:0] frame_of(input logic [7:0] d, input logic en, input logic pt);
      return (PAR_BUILT && en) ? {1'b1, ^d ^ pt, d, 1'b0} : {2'b11, d, 1'b0};
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_cyc   <= -1;
         m_len   <= 10;
         m_frame <= '1;
         m_done  <= 1'b0;
      end else if (m_cyc < 0) begin
         m_done <= 1'b0;
         if (bus.i_data_valid) begin
            m_cyc   <= 0;
            m_frame <= frame_of(bus.i_data, bus.i_en_par, bus.i_par_type);
            m_len   <= (PAR_BUILT && bus.i_en_par) ? 11 : 10;
         end
      end else begin
         m_cyc  <= (m_cyc + 1 == m_len * P) ? -1 : m_cyc + 1;
         m_done <= (m_cyc + 1 == m_len * P);
      end

   always @(negedge clk)
      if (chk_en)
         check("cycle {tx,busy,done}", 32'({bus.o_tx, bus.o_busy, bus.o_done}),
               32'({(m_cyc < 0) ? 1'b1 : m_frame[m_cyc / P], m_cyc >= 0, m_done}));

   task automatic send(input logic [7:0] d, input logic en, input logic pt, input int inj,
                       output logic [10:0] bits, output logic [10:0] bits1,
                       output int busy_n, output int done_at, output int done1_at);
      bus.i_data = d;
      bus.i_en_par = en;
      bus.i_par_type = pt;
      bus.i_data_valid = 1'b1;
      @(negedge clk);
      bus.i_data_valid = 1'b0;
      bits = '1;
      bits1 = '1;
      busy_n = 0;
      done_at = -1;
      done1_at = -1;
      for (int c = 0; c < 120 && done_at < 0; c++) begin
         if (bus.o_busy) busy_n++;
         if (bus.o_done) done_at = c;
         if (bus1.o_done && done1_at < 0) done1_at = c;
         if (c % P == P / 2 && c / P < 11) bits[c / P] = bus.o_tx;
         if (c < 11) bits1[c] = bus1.o_tx;
         bus.i_data_valid = (c == inj);
         if (c == inj) bus.i_data = 8'hFF;
         @(negedge clk);
      end
      bus.i_data_valid = 1'b0;
   endtask

   initial begin
      logic [10:0] bits, bits1, b1, b2;
      int busy_n, done_at, done1_at, extra_busy, extra_done;
      bus.i_data = 8'h00;
      bus.i_data_valid = 1'b0;
      bus.i_en_par = 1'b0;
      bus.i_par_type = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset tx", bus.o_tx, 1);
      check("reset busy", bus.o_busy, 0);
      check("reset done", bus.o_done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // plain frame 0xA5, and the same byte on the PRESCALE=1 instance
      send(8'hA5, 1'b0, 1'b0, -1, bits, bits1, busy_n, done_at, done1_at);
      check("plain bits", bits, 11'h74A);
      check("plain busy cycles", busy_n, 80);
      check("plain done edge", done_at, 80);
      check("prescale1 bits", bits1, 11'h74A);
      check("prescale1 done edge", done1_at, 10);
      // parity frames; without the parity build these stay 10 bits
      send(8'h03, 1'b1, 1'b0, -1, bits, bits1, busy_n, done_at, done1_at);
      check("even 03 bits", bits, PAR_BUILT ? 11'h406 : 11'h606);
      check("even 03 busy cycles", busy_n, PAR_BUILT ? 88 : 80);
      check("even 03 done edge", done_at, PAR_BUILT ? 88 : 80);
      send(8'h03, 1'b1, 1'b1, -1, bits, bits1, busy_n, done_at, done1_at);
      check("odd 03 bits", bits, 11'h606);
      check("odd 03 busy cycles", busy_n, PAR_BUILT ? 88 : 80);
      send(8'h07, 1'b1, 1'b1, -1, bits, bits1, busy_n, done_at, done1_at);
      check("odd 07 bits", bits, PAR_BUILT ? 11'h40E : 11'h60E);
      // request 0xFF mid-frame must be ignored
      send(8'h00, 1'b0, 1'b0, 30, bits, bits1, busy_n, done_at, done1_at);
      check("ignored req bits", bits, 11'h600);
      check("ignored req done edge", done_at, 80);
      extra_busy = 0;
      extra_done = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.o_busy) extra_busy++;
         if (bus.o_done) extra_done++;
         @(negedge clk);
      end
      check("ignored req no 2nd frame", extra_busy, 0);
      check("ignored req single done", extra_done, 0);
      // asynchronous reset during data bit 3
      bus.i_data = 8'h00;
      bus.i_data_valid = 1'b1;
      @(negedge clk);
      bus.i_data_valid = 1'b0;
      repeat (34) @(negedge clk);
      check("pre-reset tx low", bus.o_tx, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async reset tx", bus.o_tx, 1);
      check("async reset busy", bus.o_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(8'h5A, 1'b0, 1'b0, -1, bits, bits1, busy_n, done_at, done1_at);
      check("after reset 5A bits", bits, 11'h6B4);
      check("after reset done edge", done_at, 80);
      // back-to-back with valid held high
      bus.i_data = 8'h12;
      bus.i_data_valid = 1'b1;
      @(negedge clk);
      bus.i_data = 8'h34;
      b1 = '1;
      b2 = '1;
      for (int c = 0; c < 170; c++) begin
         if (c % P == P / 2 && c / P < 10) b1[c / P] = bus.o_tx;
         if (c >= 81 && (c - 81) % P == P / 2 && (c - 81) / P < 10) b2[(c - 81) / P] = bus.o_tx;
         if (c == 80) begin
            check("b2b gap busy", bus.o_busy, 0);
            check("b2b gap done", bus.o_done, 1);
         end
         if (c == 81) begin
            check("b2b 2nd start busy", bus.o_busy, 1);
            check("b2b 2nd start tx", bus.o_tx, 0);
            bus.i_data_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b first byte", b1, 11'h624);
      check("b2b second byte", b2, 11'h668);
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
